// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state encoding and small helpers for the
// three-master round-robin arbiter.
package ahb_pkg;

    localparam int NUM_MASTERS = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN   = 2'b01,
        ST_BURST = 2'b10
    } state_e;

    // Beats remaining after the NONSEQ; zero means not a fixed-length burst.
    function automatic logic [4:0] burst_beats_m1(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd7;
            HBURST_WRAP16, HBURST_INCR16: return 5'd15;
            default:                      return 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] gnt);
        case (gnt)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping modulo NUM_MASTERS.
module rr_pick
    import ahb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [1:0]             ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [1:0]             idx_o,
    output logic                   valid_o
);

    logic [2:0] sum;
    logic [1:0] cand;

    // NOTE: every output and temporary gets a default first so no latch is inferred.
    always_comb begin
        gnt_o   = '0;
        idx_o   = 2'd0;
        valid_o = 1'b0;
        sum     = 3'd0;
        cand    = 2'd0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            sum = {1'b0, ptr_i} + 3'(k);
            if (sum >= 3'(NUM_MASTERS)) sum = sum - 3'(NUM_MASTERS);
            cand = sum[1:0];
            if (!valid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Three-master AHB bus arbiter: round-robin grants, fixed-length burst
// tracking with early termination, and optional locked-transfer support.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [1:0]             hmaster,
    output logic                   hmastlock
);

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [1:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [1:0]             ptr_q, ptr_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [1:0]             pick_idx;
    logic                   pick_valid;
    logic [1:0]             own_idx;
    logic                   owner_locked;
    logic                   burst_term;
    logic                   rearb;

    rr_pick u_pick (
        .req_i   (hbusreq),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign own_idx      = onehot_to_idx(hgrant_q);
    assign owner_locked = LOCK_EN && (hgrant_q != '0) && hlock[own_idx];
    assign burst_term   = (htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ) ||
                          (hresp != HRESP_OKAY);

    always_comb begin
        state_d     = state_q;
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rearb       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    hgrant_d = pick_gnt;
                    ptr_d    = next_ptr(pick_idx);
                    state_d  = ST_OWN;
                end
            end
            ST_OWN: begin
                if (hready) begin
                    if (htrans == HTRANS_NONSEQ && burst_beats_m1(hburst) != 5'd0) begin
                        cnt_d   = burst_beats_m1(hburst);
                        state_d = ST_BURST;
                    end else begin
                        rearb = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                // A zero count while still in BURST marks a burst already cut short.
                if (hready) begin
                    if (cnt_q == 5'd0 || burst_term ||
                        (htrans == HTRANS_SEQ && cnt_q == 5'd1)) begin
                        cnt_d = 5'd0;
                        rearb = 1'b1;
                    end else if (htrans == HTRANS_SEQ) begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end else if (burst_term) begin
                    cnt_d = 5'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rearb) begin
            if (owner_locked) begin
                state_d = ST_OWN;
            end else if (pick_valid) begin
                hgrant_d = pick_gnt;
                ptr_d    = next_ptr(pick_idx);
                state_d  = ST_OWN;
            end else begin
                hgrant_d = '0;
                state_d  = ST_IDLE;
            end
        end

        // hmaster/hmastlock follow the grant one accepted cycle later (address phase).
        if (hready) begin
            if (hgrant_q != '0) begin
                hmaster_d   = own_idx;
                hmastlock_d = owner_locked;
            end else begin
                hmastlock_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            hgrant_q    <= '0;
            hmaster_q   <= 2'd0;
            hmastlock_q <= 1'b0;
            cnt_q       <= 5'd0;
            ptr_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: hand-computed grant/master/lock values
// checked one clock after each stimulus step.
module tb_ahb_rr_arbiter;
    import ahb_pkg::*;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic [2:0] hbusreq;
    logic [2:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [2:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int n_vec = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    ahb_rr_arbiter #(.LOCK_EN(1'b1)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] g, input logic [1:0] m,
                         input logic l);
        n_vec++;
        assert ({hmastlock, hmaster, hgrant} === {l, m, g})
        else begin
            n_err++;
            $error("FAIL %s: observed grant=%b master=%0d lock=%b, expected grant=%b master=%0d lock=%b",
                   tag, hgrant, hmaster, hmastlock, g, m, l);
        end
    endtask

    initial begin
        hresetn = 1'b0;
        hbusreq = 3'b000;
        hlock   = 3'b000;
        htrans  = HTRANS_IDLE;
        hburst  = HBURST_SINGLE;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        step();
        step();
        check("reset", 3'b000, 2'd0, 1'b0);

        // Round-robin with all three requesting, SINGLE NONSEQ each cycle
        hresetn = 1'b1;
        hbusreq = 3'b111;
        htrans  = HTRANS_NONSEQ;
        step(); check("rr_first_m1", 3'b001, 2'd0, 1'b0);
        step(); check("rr_m2",       3'b010, 2'd0, 1'b0);
        step(); check("rr_m3",       3'b100, 2'd1, 1'b0);
        step(); check("rr_wrap_m1",  3'b001, 2'd2, 1'b0);

        // Master 2 INCR4 with two wait states, master 1 still requesting
        hbusreq = 3'b011;
        step(); check("incr4_grant", 3'b010, 2'd0, 1'b0);
        hburst = HBURST_INCR4;
        step(); check("incr4_nonseq", 3'b010, 2'd1, 1'b0);
        htrans = HTRANS_SEQ;
        step(); check("incr4_beat2", 3'b010, 2'd1, 1'b0);
        hready = 1'b0;
        step(); check("incr4_wait1", 3'b010, 2'd1, 1'b0);
        step(); check("incr4_wait2", 3'b010, 2'd1, 1'b0);
        hready = 1'b1;
        step(); check("incr4_beat3", 3'b010, 2'd1, 1'b0);
        step(); check("incr4_done",  3'b001, 2'd1, 1'b0);

        // Master 3 INCR8 with a two-cycle ERROR on beat 3
        hbusreq = 3'b101;
        htrans  = HTRANS_IDLE;
        hburst  = HBURST_SINGLE;
        step(); check("incr8_grant", 3'b100, 2'd0, 1'b0);
        htrans = HTRANS_NONSEQ;
        hburst = HBURST_INCR8;
        step(); check("incr8_nonseq", 3'b100, 2'd2, 1'b0);
        htrans = HTRANS_SEQ;
        step(); check("incr8_beat2", 3'b100, 2'd2, 1'b0);
        hresp  = HRESP_ERROR;
        hready = 1'b0;
        step(); check("incr8_err1", 3'b100, 2'd2, 1'b0);
        hready = 1'b1;
        htrans = HTRANS_IDLE;
        step(); check("incr8_err2_handover", 3'b001, 2'd2, 1'b0);

        // Master 1 locked across two SINGLEs while master 2 requests
        hresp   = HRESP_OKAY;
        hburst  = HBURST_SINGLE;
        htrans  = HTRANS_NONSEQ;
        hbusreq = 3'b011;
        hlock   = 3'b001;
        step(); check("lock_xfer1", 3'b001, 2'd0, 1'b1);
        step(); check("lock_xfer2", 3'b001, 2'd0, 1'b1);
        hlock  = 3'b000;
        htrans = HTRANS_IDLE;
        step(); check("lock_release", 3'b010, 2'd0, 1'b0);

        // Only master 2 requests, then drops
        hbusreq = 3'b010;
        step(); check("solo_keep", 3'b010, 2'd1, 1'b0);
        hbusreq = 3'b000;
        step(); check("solo_drop_idle", 3'b000, 2'd1, 1'b0);
        step(); check("idle_hold_master", 3'b000, 2'd1, 1'b0);

        // Reset in the middle of a master 3 burst
        hbusreq = 3'b100;
        step(); check("idle_grant_m3", 3'b100, 2'd1, 1'b0);
        htrans = HTRANS_NONSEQ;
        hburst = HBURST_INCR4;
        step(); check("burst_start", 3'b100, 2'd2, 1'b0);
        htrans  = HTRANS_SEQ;
        hbusreq = 3'b111;
        hresetn = 1'b0;
        step(); check("reset_mid_burst", 3'b000, 2'd0, 1'b0);
        hresetn = 1'b1;
        htrans  = HTRANS_IDLE;
        hburst  = HBURST_SINGLE;
        step(); check("post_reset_tie_m1", 3'b001, 2'd0, 1'b0);

        // Grant must not move while hready is low
        hready = 1'b0;
        step(); check("hold_on_wait", 3'b001, 2'd0, 1'b0);
        hready = 1'b1;
        step(); check("move_on_ready", 3'b010, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
